uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command controller between uart_rx and uart_tx. Replaces the single-byte en decode.
//  Parses host command frames; drives the run enable and an 8-bit speed register.
//  Sequences a one-byte reply ('K' or 'E') per command through the shared uart_tx.
//  Holds one byte that arrives while a reply is in progress.
// PARAMETERS
//  CMD_EN       8'h31       '1': set en=1
//  CMD_DIS      8'h32       '2': set en=0
//  CMD_SPD      8'h53       'S': followed by 2 ASCII hex digits -> speed
//  SPD_DEFAULT  8'h80       speed value at reset
//  TIMEOUT_CYC  1250000     max sys_clk cycles between 'S' frame bytes (10 ms @125 MHz)
// PORTS
//  sys_clk   in   1  system clock, 125 MHz
//  reset     in   1  asynchronous reset, active-low
//  rx_done   in   1  1-cycle pulse from uart_rx: rx_data valid
//  rx_data   in   8  received byte
//  tx_busy   in   1  uart_tx busy flag
//  tx_en     out  1  1-cycle start pulse to uart_tx
//  tx_data   out  8  reply byte; stable from the tx_en cycle until the next tx_en
//  en        out  1  run enable to the datapath
//  speed     out  8  speed setting
//  cmd_err   out  1  1-cycle pulse on every 'E' reply
//  rx_ovf    out  1  sticky: a held byte was overwritten; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0, async): en=0, speed=SPD_DEFAULT, tx_en=0, tx_data=0, cmd_err=0,
//   rx_ovf=0, hold buffer empty, FSM=IDLE, timeout counter=0.
//  Byte source: in IDLE, the held byte (if valid) is consumed before a new rx_done.
//  FSM states:
//   IDLE:
//    - CMD_EN or CMD_DIS: en updates on the next edge; reply 'K' (8'h4B); -> REPLY.
//    - CMD_SPD: clear the timeout counter; -> GET_HI.
//    - 8'h0D or 8'h0A: ignored; no reply; stay in IDLE.
//    - Any other byte: reply 'E' (8'h45); -> REPLY.
//   GET_HI / GET_LO: wait for the next rx_done.
//    - Valid hex digit ('0'-'9', 'A'-'F', 'a'-'f'):
//      GET_HI latches the upper nibble; GET_LO writes speed={hi,lo} and replies 'K'.
//    - Non-hex byte: speed unchanged; reply 'E'.
//    - Timeout counter reaches TIMEOUT_CYC-1 with no rx_done: reply 'E'; -> REPLY.
//    - The counter clears on each accepted byte.
//   REPLY: wait for tx_busy=0.
//    - Then, for exactly 1 cycle: tx_en=1 with tx_data = reply byte.
//    - cmd_err=1 in the same cycle if the reply is 'E'. -> TX_WAIT.
//   TX_WAIT: stay until tx_busy=1, then -> IDLE.
//  Hold buffer: rx_done in REPLY or TX_WAIT stores rx_data in the 1-byte buffer.
//   If the buffer is already valid: overwrite it and set rx_ovf.
//  Latency: rx_done on '1' at cycle N (tx_busy=0) -> en=1 at N+1, tx_en=1 at N+2.
//  Simultaneous events: a held byte pending and rx_done in the same IDLE cycle ->
//   process the held byte; the new byte goes to the buffer.
//  Exactly one reply per command, and replies go out in command order.
//  en and speed change only on a 'K' outcome.
//  Mid-frame reset returns all state to reset values. A partial 'S' frame is discarded.
// TESTING
//  1. rx '1', tx_busy=0 -> en=1 one cycle later; tx_en pulse with tx_data=8'h4B.
//  2. rx 'S','3','c' -> speed=8'h3C; single 'K' reply; en unchanged.
//  3. rx 'S','G' -> speed stays 8'h80; tx_data=8'h45; cmd_err pulses once.
//  4. rx 'S','7', then TIMEOUT_CYC idle cycles -> 'E' reply; speed unchanged;
//     FSM back in IDLE.
//  5. tx_busy held 1; rx '1','2','2' -> rx_ovf=1; replies K,K only after busy drops;
//     final en=0.
//  6. reset=0 asserted during GET_LO -> all outputs at reset values immediately;
//     next rx '1' works normally.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Host-side byte bus for uart_cmd_ctrl: uart_rx/uart_tx handshakes plus the
// control outputs that the parsed commands drive.
interface uart_cmd_ctrl_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       en;
  logic [7:0] speed;
  logic       cmd_err;
  logic       rx_ovf;

  modport slave (
    input  rx_done, rx_data, tx_busy,
    output tx_en, tx_data, en, speed, cmd_err, rx_ovf
  );

  modport master (
    output rx_done, rx_data, tx_busy,
    input  tx_en, tx_data, en, speed, cmd_err, rx_ovf
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command controller between uart_rx and uart_tx: parses '1' / '2' / 'S'hh frames,
// drives en and speed, and sends one 'K'/'E' reply byte per command.
module uart_cmd_ctrl #(
  parameter logic [7:0] CMD_EN      = 8'h31,
  parameter logic [7:0] CMD_DIS     = 8'h32,
  parameter logic [7:0] CMD_SPD     = 8'h53,
  parameter logic [7:0] SPD_DEFAULT = 8'h80,
  parameter int         TIMEOUT_CYC = 1250000
) (
  input  logic            i_sys_clk,
  input  logic            i_reset,
  uart_cmd_ctrl_if.slave  bus
);

  localparam int         CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] REPLY_K = 8'h4B;
  localparam logic [7:0] REPLY_E = 8'h45;

  typedef enum logic [2:0] {
    IDLE, GET_HI, GET_LO, REPLY, TX_WAIT
  } state_t;

  state_t           r_state, w_state_next;
  logic             r_en, w_en_next;
  logic [7:0]       r_speed, w_speed_next;
  logic [3:0]       r_hi, w_hi_next;
  logic [7:0]       r_reply, w_reply_next;
  logic             r_tx_en, w_tx_en_next;
  logic [7:0]       r_tx_data, w_tx_data_next;
  logic             r_cmd_err, w_cmd_err_next;
  logic             r_hold_vld, w_hold_vld_next;
  logic [7:0]       r_hold_data, w_hold_data_next;
  logic             r_ovf, w_ovf_next;
  logic [CNT_W-1:0] r_tmo_cnt, w_tmo_cnt_next;

  logic             w_src_vld;
  logic [7:0]       w_src;
  logic [4:0]       w_hex;

  // {valid, nibble} for an ASCII hex digit
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'b0;
  endfunction

  // A held byte is always older than one arriving now, so it is parsed first
  assign w_src_vld = r_hold_vld | bus.rx_done;
  assign w_src     = r_hold_vld ? r_hold_data : bus.rx_data;
  assign w_hex     = hex_dec(w_src);

  always_comb begin
    w_state_next     = r_state;
    w_en_next        = r_en;
    w_speed_next     = r_speed;
    w_hi_next        = r_hi;
    w_reply_next     = r_reply;
    w_tx_en_next     = 1'b0;
    w_tx_data_next   = r_tx_data;
    w_cmd_err_next   = 1'b0;
    w_hold_vld_next  = r_hold_vld;
    w_hold_data_next = r_hold_data;
    w_ovf_next       = r_ovf;
    w_tmo_cnt_next   = r_tmo_cnt;

    if (r_state == REPLY || r_state == TX_WAIT) begin
      if (bus.rx_done) begin
        w_hold_vld_next  = 1'b1;
        w_hold_data_next = bus.rx_data;
        w_ovf_next       = r_ovf | r_hold_vld;
      end
    end else if (w_src_vld && r_hold_vld) begin
      w_hold_vld_next  = bus.rx_done;
      w_hold_data_next = bus.rx_done ? bus.rx_data : r_hold_data;
    end

    case (r_state)
      IDLE: begin
        if (w_src_vld) begin
          if (w_src == CMD_EN || w_src == CMD_DIS) begin
            w_en_next    = (w_src == CMD_EN);
            w_reply_next = REPLY_K;
            w_state_next = REPLY;
          end else if (w_src == CMD_SPD) begin
            w_tmo_cnt_next = '0;
            w_state_next   = GET_HI;
          end else if (w_src != 8'h0D && w_src != 8'h0A) begin
            w_reply_next = REPLY_E;
            w_state_next = REPLY;
          end
        end
      end
      GET_HI, GET_LO: begin
        if (w_src_vld) begin
          w_tmo_cnt_next = '0;
          if (!w_hex[4]) begin
            w_reply_next = REPLY_E;
            w_state_next = REPLY;
          end else if (r_state == GET_HI) begin
            w_hi_next    = w_hex[3:0];
            w_state_next = GET_LO;
          end else begin
            w_speed_next = {r_hi, w_hex[3:0]};
            w_reply_next = REPLY_K;
            w_state_next = REPLY;
          end
        end else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_reply_next = REPLY_E;
          w_state_next = REPLY;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + 1'b1;
        end
      end
      REPLY: begin
        if (!bus.tx_busy) begin
          w_tx_en_next   = 1'b1;
          w_tx_data_next = r_reply;
          w_cmd_err_next = (r_reply == REPLY_E);
          w_state_next   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // Wait for uart_tx to acknowledge so the next reply cannot overrun it
        if (bus.tx_busy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_en        <= 1'b0;
      r_speed     <= SPD_DEFAULT;
      r_hi        <= 4'd0;
      r_reply     <= 8'd0;
      r_tx_en     <= 1'b0;
      r_tx_data   <= 8'd0;
      r_cmd_err   <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= 8'd0;
      r_ovf       <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_en        <= w_en_next;
      r_speed     <= w_speed_next;
      r_hi        <= w_hi_next;
      r_reply     <= w_reply_next;
      r_tx_en     <= w_tx_en_next;
      r_tx_data   <= w_tx_data_next;
      r_cmd_err   <= w_cmd_err_next;
      r_hold_vld  <= w_hold_vld_next;
      r_hold_data <= w_hold_data_next;
      r_ovf       <= w_ovf_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
    end
  end

  assign bus.tx_en   = r_tx_en;
  assign bus.tx_data = r_tx_data;
  assign bus.en      = r_en;
  assign bus.speed   = r_speed;
  assign bus.cmd_err = r_cmd_err;
  assign bus.rx_ovf  = r_ovf;

endmodule
